// File: rtl/byte_striping.sv
// Transmit-side byte striper: spreads a byte stream round-robin over four lanes
// and publishes each completed (or flushed) group as one registered word set.
module byte_striping #(
  parameter logic [7:0] PAD = 8'h00
) (
  input  logic       clk1M,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       flush,
  output logic [7:0] Lane_0,
  output logic [7:0] Lane_1,
  output logic [7:0] Lane_2,
  output logic [7:0] Lane_3,
  output logic       group_valid,
  output logic [1:0] ctr_3
);

  // Interface: valid_in qualifies data_in for exactly one clk1M cycle; there is
  // no ready, so every valid byte is accepted. group_valid pulses for one cycle
  // on the edge that loads Lane_0..Lane_3; lanes then hold until the next pulse.
  // ctr_3 is the only state: 0 = EMPTY, 1..3 = FILLING (next lane to write).

  logic [7:0] buf0, buf1, buf2;
  logic [7:0] staged [4];
  logic [7:0] next_lane [4];
  logic       publish;

  always_comb begin
    publish = (valid_in && (flush || ctr_3 == 2'd3)) ||
              (flush && !valid_in && ctr_3 != 2'd0);
  end

  // Lanes below ctr_3 come from staging, lane ctr_3 takes a valid byte, the rest pad.
  always_comb begin
    staged[0] = buf0;
    staged[1] = buf1;
    staged[2] = buf2;
    staged[3] = PAD;
    for (int i = 0; i < 4; i++) begin
      next_lane[i] = PAD;
      if (2'(i) < ctr_3)
        next_lane[i] = staged[i];
      else if (2'(i) == ctr_3 && valid_in)
        next_lane[i] = data_in;
    end
  end

  always_ff @(posedge clk1M or posedge reset) begin
    if (reset) begin
      Lane_0      <= 8'h00;
      Lane_1      <= 8'h00;
      Lane_2      <= 8'h00;
      Lane_3      <= 8'h00;
      group_valid <= 1'b0;
      ctr_3       <= 2'd0;
      buf0        <= 8'h00;
      buf1        <= 8'h00;
      buf2        <= 8'h00;
    end else begin
      group_valid <= publish;
      if (publish) begin
        Lane_0 <= next_lane[0];
        Lane_1 <= next_lane[1];
        Lane_2 <= next_lane[2];
        Lane_3 <= next_lane[3];
        ctr_3  <= 2'd0;
      end else if (valid_in) begin
        case (ctr_3)
          2'd0:    buf0 <= data_in;
          2'd1:    buf1 <= data_in;
          default: buf2 <= data_in;
        endcase
        ctr_3 <= ctr_3 + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_byte_striping.sv
// Directed bench for byte_striping: two instances (PAD 00 and PAD F7) share
// stimulus; expected lane words are hand-computed constants.
`timescale 1ns/1ps
module tb_byte_striping;

  logic       clk1M;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       flush;

  logic [7:0] l0_a, l1_a, l2_a, l3_a;
  logic [7:0] l0_b, l1_b, l2_b, l3_b;
  logic       gv_a, gv_b;
  logic [1:0] ctr_a, ctr_b;
  logic [31:0] lanes_a, lanes_b;

  int vectors;
  int miscompares;

  assign lanes_a = {l0_a, l1_a, l2_a, l3_a};
  assign lanes_b = {l0_b, l1_b, l2_b, l3_b};

  byte_striping u_dut (
    .clk1M(clk1M), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .flush(flush), .Lane_0(l0_a), .Lane_1(l1_a), .Lane_2(l2_a), .Lane_3(l3_a),
    .group_valid(gv_a), .ctr_3(ctr_a)
  );

  byte_striping #(.PAD(8'hF7)) u_dut_f7 (
    .clk1M(clk1M), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .flush(flush), .Lane_0(l0_b), .Lane_1(l1_b), .Lane_2(l2_b), .Lane_3(l3_b),
    .group_valid(gv_b), .ctr_3(ctr_b)
  );

  // clock / reset
  initial clk1M = 1'b0;
  always #5 clk1M = ~clk1M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, then sample 1ns after the rising edge.
  task automatic step(input logic [7:0] d, input logic v, input logic f);
    @(negedge clk1M);
    data_in  = d;
    valid_in = v;
    flush    = f;
    @(posedge clk1M);
    #1;
  endtask

  task automatic idle();
    step(8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_pub(input string tag, input logic [31:0] exp_a, input logic [31:0] exp_b);
    check({tag, "_lanes"},    lanes_a, exp_a);
    check({tag, "_lanes_f7"}, lanes_b, exp_b);
    check({tag, "_gv"},       {31'd0, gv_a}, 32'd1);
    check({tag, "_gv_f7"},    {31'd0, gv_b}, 32'd1);
    check({tag, "_ctr"},      {30'd0, ctr_a}, 32'd0);
  endtask

  logic [7:0] seq [8];

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b1;
    data_in  = 8'h00;
    valid_in = 1'b0;
    flush    = 1'b0;
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    repeat (2) @(negedge clk1M);
    check("rst_lanes", lanes_a, 32'h0);
    check("rst_gv",    {31'd0, gv_a}, 32'd0);
    check("rst_ctr",   {30'd0, ctr_a}, 32'd0);
    reset = 1'b0;

    // continuous stream, two full groups
    for (int k = 0; k < 8; k++) begin
      step(seq[k], 1'b1, 1'b0);
      check($sformatf("cont_ctr%0d", k), {30'd0, ctr_a}, 32'((k + 1) % 4));
      check($sformatf("cont_gv%0d", k),  {31'd0, gv_a}, 32'(k % 4 == 3));
      if (k < 3)
        check($sformatf("cont_hold%0d", k), lanes_a, 32'h0000_0000);
      else if (k < 7)
        check($sformatf("cont_lanes%0d", k), lanes_a, 32'h1122_3344);
      else
        check("cont_lanes7", lanes_a, 32'h5566_7788);
    end
    idle();
    check("cont_gv_drop", {31'd0, gv_a}, 32'd0);

    // partial group closed by flush without data
    step(8'hA1, 1'b1, 1'b0);
    step(8'hA2, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    check_pub("flush_a", 32'hA1A2_0000, 32'hA1A2_F7F7);
    idle();
    check("flush_a_single", {31'd0, gv_a}, 32'd0);
    step(8'hB0, 1'b1, 1'b0);
    check("b0_ctr",  {30'd0, ctr_a}, 32'd1);
    check("b0_hold", lanes_a, 32'hA1A2_0000);
    step(8'h00, 1'b0, 1'b1);
    check_pub("flush_b", 32'hB000_0000, 32'hB0F7_F7F7);

    // flush carrying the last byte
    step(8'hC1, 1'b1, 1'b0);
    step(8'hC2, 1'b1, 1'b0);
    step(8'hC3, 1'b1, 1'b1);
    check_pub("flush_c", 32'hC1C2_C300, 32'hC1C2_C3F7);
    step(8'h00, 1'b0, 1'b1);
    check("flush_empty_gv",    {31'd0, gv_a}, 32'd0);
    check("flush_empty_lanes", lanes_b, 32'hC1C2_C3F7);
    check("flush_empty_ctr",   {30'd0, ctr_a}, 32'd0);

    // one-byte group and flush coinciding with a normal completion
    step(8'h5A, 1'b1, 1'b1);
    check_pub("flush_one", 32'h5A00_0000, 32'h5AF7_F7F7);
    step(8'h01, 1'b1, 1'b0);
    step(8'h02, 1'b1, 1'b0);
    step(8'h03, 1'b1, 1'b0);
    step(8'h04, 1'b1, 1'b1);
    check_pub("flush_full", 32'h0102_0304, 32'h0102_0304);

    // gapped input
    step(8'hD1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle();
      check($sformatf("gap_ctr%0d", k),  {30'd0, ctr_a}, 32'd1);
      check($sformatf("gap_hold%0d", k), lanes_a, 32'h0102_0304);
    end
    step(8'hD2, 1'b1, 1'b0);
    step(8'hD3, 1'b1, 1'b0);
    idle();
    check("gap_ctr3",  {30'd0, ctr_a}, 32'd3);
    check("gap_gv",    {31'd0, gv_a}, 32'd0);
    step(8'hD4, 1'b1, 1'b0);
    check_pub("gap_pub", 32'hD1D2_D3D4, 32'hD1D2_D3D4);

    // asynchronous reset mid-group
    step(8'hE1, 1'b1, 1'b0);
    step(8'hE2, 1'b1, 1'b0);
    check("e_ctr", {30'd0, ctr_a}, 32'd2);
    @(negedge clk1M);
    valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_lanes",    lanes_a, 32'h0);
    check("arst_lanes_f7", lanes_b, 32'h0);
    check("arst_ctr",      {30'd0, ctr_a}, 32'd0);
    check("arst_gv",       {31'd0, gv_a}, 32'd0);
    @(negedge clk1M);
    reset = 1'b0;
    step(8'hF1, 1'b1, 1'b0);
    check("f1_ctr", {30'd0, ctr_a}, 32'd1);
    step(8'hF2, 1'b1, 1'b0);
    step(8'hF3, 1'b1, 1'b0);
    step(8'hF4, 1'b1, 1'b0);
    check_pub("post_rst", 32'hF1F2_F3F4, 32'hF1F2_F3F4);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/byte_striping.md
Name: byte_striping

Overview:
- Transmit-side counterpart of the byte-joining stage.
- Takes a byte stream on the fast byte clock and distributes consecutive bytes round-robin across four lanes (byte 0 to Lane_0 … byte 3 to Lane_3).
- Publishes each completed 4-byte group as one aligned, registered word set toward the parallel-to-serial stage, with a one-cycle strobe.
- A flush input closes a partial group by padding the unfilled lanes.

Parameters:
- PAD, 8'h00: byte written into lanes left unfilled when a partial group is flushed.

Ports:
- clk1M  input  1  byte clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  incoming byte.
- valid_in  input  1  data_in is valid this cycle.
- flush  input  1  close the current group; pad the remaining lanes with PAD.
- Lane_0  output  8  group byte 0 (first received), held between publishes.
- Lane_1  output  8  group byte 1.
- Lane_2  output  8  group byte 2.
- Lane_3  output  8  group byte 3.
- group_valid  output  1  one-cycle pulse: Lane_0..Lane_3 updated this cycle.
- ctr_3  output  2  current write lane index (0..3); same encoding as the join-side select.

Behaviour:
- Reset (async, active-high): Lane_0..Lane_3 = 8'h00, group_valid = 0, ctr_3 = 0, internal staging bytes buf0..buf2 = 8'h00. Any partial group is discarded. Reset mid-group: the next valid byte after release goes to lane 0.
- States:
  - EMPTY (ctr_3 == 0).
  - FILLING (ctr_3 in 1..3).
  - State is fully encoded by ctr_3; no other state register.
- valid_in=1, flush=0, ctr_3 < 3: buf[ctr_3] <= data_in; ctr_3 <= ctr_3 + 1; lanes unchanged; group_valid <= 0.
- valid_in=1, flush=0, ctr_3 == 3 (completing byte):
  - Lane_0..2 <= buf0..buf2, Lane_3 <= data_in.
  - group_valid <= 1; ctr_3 <= 0 (2-bit wrap).
  - Latency: last byte sampled at edge N appears on Lane_3 with group_valid=1 after edge N, i.e. 1 cycle.
- flush=1, valid_in=1:
  - data_in occupies lane ctr_3; lanes above ctr_3 <= PAD; lanes below take buf.
  - Publish: group_valid <= 1, ctr_3 <= 0.
  - Applies for every ctr_3, including 0 (one-byte group) and 3 (a normal completion).
- flush=1, valid_in=0, ctr_3 != 0: lanes 0..ctr_3-1 from buf, lanes ctr_3..3 <= PAD; publish; ctr_3 <= 0.
- flush=1, valid_in=0, ctr_3 == 0: no-op; nothing published, group_valid <= 0.
- valid_in=0, flush=0: hold all state; group_valid <= 0.
- Lane outputs change only on a publish edge and hold otherwise.
- group_valid is never high two cycles in a row except on back-to-back completions; each publish is exactly one pulse.
- Continuous valid_in: one publish every 4 cycles. Lanes are stable for 4 clk1M cycles, which covers one clk250k period downstream.
- No backpressure: the downstream stage must sample within 4 cycles of group_valid. Bytes are never dropped internally.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset asserted asynchronously mid-cycle → all Lane_x = 00, group_valid = 0, ctr_3 = 0 immediately, without waiting for a clock edge.
2. Continuous valid_in with bytes 11,22,33,44,55,66,77,88 →
   - group_valid pulses on the 4th and 8th edges.
   - Lanes = 11/22/33/44, then 55/66/77/88.
   - ctr_3 sequence 1,2,3,0,1,2,3,0.
3. Bytes A1,A2 then flush with valid_in=0 (PAD=00) → Lanes = A1/A2/00/00, single group_valid pulse, ctr_3 = 0. A following byte B0 lands in Lane_0 of the next group.
4. Bytes C1,C2 then valid_in=1 data C3 with flush=1; repeat the run with PAD=F7 → Lanes = C1/C2/C3/F7, one pulse. Flush alone at ctr_3 = 0 → no pulse, lanes unchanged.
5. Gapped input: D1, idle 3 cycles, D2, D3, idle, D4 → single publish D1/D2/D3/D4. ctr_3 holds during idle cycles; lanes hold the previous group until the publish.
6. Reset during FILLING after E1,E2, then release and send F1..F4 → Lanes = F1/F2/F3/F4; E bytes never appear.
